// File: rtl/hr_pkg.sv
// Shared flit layout and helpers for the hierarchical-ring node.
package hr_pkg;

    localparam int FLIT_W    = 144;
    localparam int ADDR_W    = 4;
    localparam int VALID_BIT = 143;
    localparam int DEST_HI   = 142;
    localparam int DEST_LO   = 139;
    localparam int SRC_HI    = 138;
    localparam int SRC_LO    = 135;

    localparam logic [FLIT_W-1:0] FLIT_IDLE = '0;

    function automatic logic flit_valid(input logic [FLIT_W-1:0] f);
        return f[VALID_BIT];
    endfunction

    function automatic logic [ADDR_W-1:0] flit_dest(input logic [FLIT_W-1:0] f);
        return f[DEST_HI:DEST_LO];
    endfunction

endpackage

// File: rtl/hr_lane.sv
// One ring lane: eject/forward/inject decision and registered outputs.
// Optional HRNODE_LOOPBACK_EN: self-addressed local flits skip the ring.
module hr_lane
    import hr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [FLIT_W-1:0] ring_i,
    input  logic [FLIT_W-1:0] local_i,
    output logic              ack_o,
    output logic [FLIT_W-1:0] ring_o,
    output logic [FLIT_W-1:0] local_o
);

    logic [FLIT_W-1:0] ring_d,  ring_q;
    logic [FLIT_W-1:0] local_d, local_q;
    logic              ring_vld;
    logic              eject;
    logic              slot_free;
    logic              local_vld;

    assign ring_vld  = flit_valid(ring_i);
    assign eject     = ring_vld && (flit_dest(ring_i) == addr_i);
    assign slot_free = !ring_vld || eject;
    assign local_vld = flit_valid(local_i);

`ifdef HRNODE_LOOPBACK_EN
    logic loop;
    assign loop = local_vld && (flit_dest(local_i) == addr_i);

    // A looped-back flit competes for the ejection register, not the ring slot.
    always_comb begin
        ack_o   = 1'b0;
        ring_d  = FLIT_IDLE;
        local_d = FLIT_IDLE;
        if (eject) begin
            local_d = ring_i;
        end
        if (ring_vld && !eject) begin
            ring_d = ring_i;
        end
        if (rst_n && loop && !eject) begin
            ack_o   = 1'b1;
            local_d = local_i;
        end else if (rst_n && !loop && local_vld && slot_free) begin
            ack_o  = 1'b1;
            ring_d = local_i;
        end
    end
`else
    always_comb begin
        ack_o   = 1'b0;
        ring_d  = FLIT_IDLE;
        local_d = FLIT_IDLE;
        if (eject) begin
            local_d = ring_i;
        end
        if (ring_vld && !eject) begin
            ring_d = ring_i;
        end else if (rst_n && local_vld) begin
            ack_o  = 1'b1;
            ring_d = local_i;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q  <= FLIT_IDLE;
            local_q <= FLIT_IDLE;
        end else begin
            ring_q  <= ring_d;
            local_q <= local_d;
        end
    end

    assign ring_o  = ring_q;
    assign local_o = local_q;

endmodule

// File: rtl/hr_node.sv
// Bufferless hierarchical-ring router node: two independent lanes sharing addr.
// Optional HRNODE_LOOPBACK_EN is handled inside hr_lane.
module hr_node
    import hr_pkg::*;
#(
    parameter logic [ADDR_W-1:0] addr = 4'b0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] port0_i,
    input  logic [FLIT_W-1:0] port1_i,
    input  logic [FLIT_W-1:0] port0_local_i,
    input  logic [FLIT_W-1:0] port1_local_i,
    output logic              portl0_ack,
    output logic              portl1_ack,
    output logic [FLIT_W-1:0] port0_o,
    output logic [FLIT_W-1:0] port1_o,
    output logic [FLIT_W-1:0] port0_local_o,
    output logic [FLIT_W-1:0] port1_local_o
);

    hr_lane u_lane0 (
        .clk     (clk),
        .rst_n   (rst),
        .addr_i  (addr),
        .ring_i  (port0_i),
        .local_i (port0_local_i),
        .ack_o   (portl0_ack),
        .ring_o  (port0_o),
        .local_o (port0_local_o)
    );

    hr_lane u_lane1 (
        .clk     (clk),
        .rst_n   (rst),
        .addr_i  (addr),
        .ring_i  (port1_i),
        .local_i (port1_local_i),
        .ack_o   (portl1_ack),
        .ring_o  (port1_o),
        .local_o (port1_local_o)
    );

endmodule

// File: tb/tb_hr_node.sv
// Directed table-driven bench for hr_node (addr = 4'h2), both macro builds.
module tb_hr_node;
    import hr_pkg::*;

    logic              clk;
    logic              rst;
    logic [FLIT_W-1:0] port0_i, port1_i, port0_local_i, port1_local_i;
    logic              portl0_ack, portl1_ack;
    logic [FLIT_W-1:0] port0_o, port1_o, port0_local_o, port1_local_o;

    int n_chk  = 0;
    int n_fail = 0;

    hr_node #(.addr(4'b0010)) dut (
        .clk           (clk),
        .rst           (rst),
        .port0_i       (port0_i),
        .port1_i       (port1_i),
        .port0_local_i (port0_local_i),
        .port1_local_i (port1_local_i),
        .portl0_ack    (portl0_ack),
        .portl1_ack    (portl1_ack),
        .port0_o       (port0_o),
        .port1_o       (port1_o),
        .port0_local_o (port0_local_o),
        .port1_local_o (port1_local_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [FLIT_W-1:0] p0, p1, l0, l1;
        logic              ack0, ack1;
        logic [FLIT_W-1:0] e_p0, e_p1, e_l0, e_l1;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [FLIT_W-1:0] fl(input logic v, input logic [3:0] d,
                                             input logic [3:0] s, input logic [134:0] p);
        return {v, d, s, p};
    endfunction

    task automatic chk(input string name, input logic [FLIT_W-1:0] act,
                       input logic [FLIT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [FLIT_W-1:0] p0, input logic [FLIT_W-1:0] p1,
                         input logic [FLIT_W-1:0] l0, input logic [FLIT_W-1:0] l1);
        port0_i       = p0;
        port1_i       = p1;
        port0_local_i = l0;
        port1_local_i = l1;
    endtask

    logic [FLIT_W-1:0] f_pass, f_ej1, f_ring9, f_loc7, f_ej0, f_r3, f_loc2, f_ej1b, f_inv;

    initial begin
        f_pass  = fl(1'b1, 4'h5, 4'h1, 135'hABCD);
        f_ej1   = fl(1'b1, 4'h2, 4'h4, 135'h1234);
        f_ring9 = fl(1'b1, 4'h9, 4'h3, 135'h5555);
        f_loc7  = fl(1'b1, 4'h7, 4'h2, 135'h7777);
        f_ej0   = fl(1'b1, 4'h2, 4'h6, 135'h0BAD);
        f_r3    = fl(1'b1, 4'h3, 4'h8, 135'h3333);
        f_loc2  = fl(1'b1, 4'h2, 4'h2, 135'h2222);
        f_ej1b  = fl(1'b1, 4'h2, 4'hA, 135'hCAFE);
        f_inv   = fl(1'b0, 4'h2, 4'h1, 135'hDEAD);

        //            name          p0       p1      l0      l1      ack0  ack1  e_p0     e_p1    e_l0     e_l1
        vecs[0] = '{"idle",        '0,      '0,     '0,     '0,     1'b0, 1'b0, '0,      '0,     '0,      '0};
        vecs[1] = '{"pass0",       f_pass,  '0,     '0,     '0,     1'b0, 1'b0, f_pass,  '0,     '0,      '0};
        vecs[2] = '{"eject1",      '0,      f_ej1,  '0,     '0,     1'b0, 1'b0, '0,      '0,     '0,      f_ej1};
        vecs[3] = '{"inj_block0",  f_ring9, '0,     f_loc7, '0,     1'b0, 1'b0, f_ring9, '0,     '0,      '0};
        vecs[4] = '{"inj_grant0",  '0,      '0,     f_loc7, '0,     1'b1, 1'b0, f_loc7,  '0,     '0,      '0};
        vecs[5] = '{"ej_inj0",     f_ej0,   '0,     f_loc7, '0,     1'b1, 1'b0, f_loc7,  '0,     f_ej0,   '0};
        vecs[6] = '{"both_lanes",  '0,      f_r3,   f_pass, f_loc7, 1'b1, 1'b0, f_pass,  f_r3,   '0,      '0};
`ifdef HRNODE_LOOPBACK_EN
        vecs[7] = '{"self_loc1",   '0,      '0,     '0,     f_loc2, 1'b0, 1'b1, '0,      '0,     '0,      f_loc2};
        vecs[8] = '{"self_ej1",    '0,      f_ej1b, '0,     f_loc2, 1'b0, 1'b0, '0,      '0,     '0,      f_ej1b};
`else
        vecs[7] = '{"self_loc1",   '0,      '0,     '0,     f_loc2, 1'b0, 1'b1, '0,      f_loc2, '0,      '0};
        vecs[8] = '{"self_ej1",    '0,      f_ej1b, '0,     f_loc2, 1'b0, 1'b1, '0,      f_loc2, '0,      f_ej1b};
`endif
        vecs[9] = '{"invalid_rng", f_inv,   '0,     '0,     '0,     1'b0, 1'b0, '0,      '0,     '0,      '0};

        // Reset held: outputs clear and acks stay low even with a free slot and a local flit.
        rst = 1'b0;
        drive('0, '0, f_loc7, f_loc7);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ack0", {143'd0, portl0_ack}, '0);
        chk("rst_ack1", {143'd0, portl1_ack}, '0);
        chk("rst_p0_o", port0_o, '0);
        chk("rst_p1_o", port1_o, '0);
        chk("rst_l0_o", port0_local_o, '0);
        chk("rst_l1_o", port1_local_o, '0);

        @(negedge clk);
        drive('0, '0, '0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_p0_o", port0_o, '0);
        chk("rel_l1_o", port1_local_o, '0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].p0, vecs[i].p1, vecs[i].l0, vecs[i].l1);
            #1;
            chk({vecs[i].name, ".ack0"}, {143'd0, portl0_ack}, {143'd0, vecs[i].ack0});
            chk({vecs[i].name, ".ack1"}, {143'd0, portl1_ack}, {143'd0, vecs[i].ack1});
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".p0_o"}, port0_o, vecs[i].e_p0);
            chk({vecs[i].name, ".p1_o"}, port1_o, vecs[i].e_p1);
            chk({vecs[i].name, ".l0_o"}, port0_local_o, vecs[i].e_l0);
            chk({vecs[i].name, ".l1_o"}, port1_local_o, vecs[i].e_l1);
        end

        // Back-to-back stream on lane 0: each output reflects only the previous cycle.
        @(negedge clk);
        drive(f_pass, f_ej1, '0, '0);
        @(posedge clk);
        @(negedge clk);
        drive(f_ej0, '0, '0, '0);
        #1;
        chk("seq.p0_o_hold", port0_o, f_pass);
        chk("seq.l1_o_hold", port1_local_o, f_ej1);
        @(posedge clk);
        #1;
        chk("seq.p0_o_idle", port0_o, '0);
        chk("seq.l0_o_ej", port0_local_o, f_ej0);
        chk("seq.l1_o_idle", port1_local_o, '0);

        // Mid-operation asynchronous reset flushes in-flight flits immediately.
        @(negedge clk);
        drive(f_pass, f_r3, '0, '0);
        @(posedge clk);
        #2;
        chk("mid.p0_o_pre", port0_o, f_pass);
        rst = 1'b0;
        #1;
        chk("mid.p0_o", port0_o, '0);
        chk("mid.p1_o", port1_o, '0);
        chk("mid.l0_o", port0_local_o, '0);
        @(negedge clk);
        drive('0, '0, '0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post.p0_o", port0_o, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hr_node.md
Name: hr_node

Overview:
- Bufferless hierarchical-ring router node with two independent ring lanes (lane 0, lane 1), each with one ring input and one ring output.
- Each lane has one local injection port and one local ejection port.
- Flits addressed to this node are ejected to the local port; all other flits are forwarded downstream.
- Local flits are injected into free ring slots, and each accepted injection is acknowledged in the same cycle.

Parameters:
- addr, 4'b0010, 4-bit node address; compared against the flit destination field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset asserted).
- port0_i  in  144  lane-0 ring input flit.
- port1_i  in  144  lane-1 ring input flit.
- port0_local_i  in  144  lane-0 local injection flit.
- port1_local_i  in  144  lane-1 local injection flit.
- portl0_ack  out  1  lane-0 injection accepted this cycle.
- portl1_ack  out  1  lane-1 injection accepted this cycle.
- port0_o  out  144  lane-0 ring output flit (registered).
- port1_o  out  144  lane-1 ring output flit (registered).
- port0_local_o  out  144  lane-0 ejected flit (registered).
- port1_local_o  out  144  lane-1 ejected flit (registered).

Behaviour:
- Flit format (144 bits):
  - bit 143 = valid.
  - bits [142:139] = dest.
  - bits [138:135] = src.
  - bits [134:0] = payload.
  - An all-zero flit is idle.
- Reset (rst==0, asynchronous): all four flit outputs clear to 144'h0; both acks are 0 while in reset.
- The two lanes are fully independent and identical; the rules below apply per lane i.
- Ejection: if port_i valid and dest==addr, then next cycle port_i_local_o = port_i and the ring slot is freed.
- Forwarding: if port_i valid and dest!=addr, then next cycle port_i_o = port_i unchanged. Ring traffic always has priority and is never dropped or stalled.
- Injection: a slot is free when port_i is invalid or is being ejected.
  - If the slot is free and the local input is valid, then portl_i_ack=1 combinationally in the same cycle, and next cycle port_i_o = local flit.
  - Otherwise ack=0 and the source must hold its flit until acked.
- Self-addressed local flits (dest==addr) are injected onto the ring like any other and return after one full ring revolution (macro off).
- Idle cycles: the corresponding output register loads 144'h0 (no stale valids).
- Latency: ring input to ring/local output is 1 cycle; local injection to ring output is 1 cycle.
- Simultaneous ejection and injection on the same lane in the same cycle is legal: both outputs update.
- Reset asserted mid-operation flushes in-flight flits; no recovery.

Optional Feature:
- HRNODE_LOOPBACK_EN.
- Defined: a valid local flit with dest==addr bypasses the ring. If the lane is not ejecting a ring flit this cycle, it is acked and written to port_i_local_o next cycle, and the ring slot stays available. If the lane is ejecting, ack=0.
- Undefined: self-addressed flits take the ring path as described under Behaviour.

Decomposition:
- Shared package `hr_pkg` holds:
  - FLIT_W=144;
  - field positions VALID_BIT, DEST_HI/LO, SRC_HI/LO;
  - ADDR_W=4;
  - idle-flit constant.
- One sub-module `hr_lane`: the per-lane eject/forward/inject logic and output registers. `hr_node` instantiates it twice, sharing addr.

Test Plan:
- Reset and idle:
  - Hold rst=0 with all inputs 0 and pulse clk → all four outputs 144'h0, acks 0.
  - Release rst with inputs still 0 → outputs remain 0.
- Pass-through: port0_i = valid, dest=4'h5, payload 0xABCD → port0_o equals it one cycle later; port0_local_o=0.
- Eject: port1_i = valid, dest=4'h2 → port1_local_o equals it next cycle; port1_o=0.
- Inject blocked then granted:
  - port0_local_i valid (dest=4'h7) while port0_i carries a flit with dest=4'h9 → portl0_ack=0; port0_o = the ring flit.
  - Next cycle port0_i idle → ack=1; port0_o = the local flit.
- Simultaneous eject and inject: port0_i dest=4'h2 plus a valid port0_local_i → ack=1; next cycle port0_local_o = the ring flit and port0_o = the local flit.
- Loopback (HRNODE_LOOPBACK_EN defined): port1_local_i dest=4'h2 with the ring idle → ack=1; port1_local_o = that flit next cycle; port1_o=0.
